spi_xfer_fifo_seq: RTL
======================

// Module: spi_xfer_fifo_seq
// PURPOSE
//  Byte-stream sequencer between the APB register layer and the spi_master core.
//  Buffers outgoing bytes in a TX FIFO and issues one go pulse per byte to the core.
//  Captures each received byte (datao at done) into an RX FIFO.
//  Removes per-byte CPU polling for multi-byte SPI transactions.
// PARAMETERS
//  DW  8  data width per transfer; must match spi_master DATA_WIDTH
//  AW  2  FIFO address width; both FIFOs have depth 2**AW (default 4)
// PORTS
//  PCLK         in   1      clock
//  PRESETn      in   1      asynchronous active-low reset
//  en           in   1      1 = sequencer may start new transfers
//  flush        in   1      pulse: empty both FIFOs
//  err_clr      in   1      pulse: clear tx_ovf and rx_udf
//  tx_wr        in   1      push tx_wdata into TX FIFO
//  tx_wdata     in   DW     byte to transmit
//  rx_rd        in   1      pop RX FIFO head
//  rx_rdata     out  DW     RX FIFO head (show-ahead); 0 when empty
//  tx_full      out  1      TX level == 2**AW
//  tx_empty     out  1      TX level == 0
//  tx_level     out  AW+1   TX occupancy
//  rx_full      out  1      RX level == 2**AW
//  rx_empty     out  1      RX level == 0
//  rx_level     out  AW+1   RX occupancy
//  tx_ovf       out  1      sticky: tx_wr seen while tx_full
//  rx_udf       out  1      sticky: rx_rd seen while rx_empty
//  xfer_active  out  1      state != IDLE
//  go           out  1      to spi_master: one-cycle start pulse
//  datai        out  DW     to spi_master: byte for current transfer, held stable
//  datao        in   DW     from spi_master: received byte, valid when done=1
//  busy         in   1      from spi_master: transfer in progress
//  done         in   1      from spi_master: one-cycle end-of-transfer pulse
// BEHAVIOUR
//  Reset: FIFOs empty, state IDLE, go=0, datai=0, tx_ovf=rx_udf=0,
//   xfer_active=0, rx_rdata=0.
//  FIFOs: circular buffers with AW-bit rd/wr pointers that wrap modulo 2**AW.
//   Level is AW+1 bits.
//  TX push: tx_wr & ~tx_full writes at wr_ptr. tx_level and tx_empty update the next cycle.
//   tx_wr & tx_full drops the byte and sets tx_ovf. This holds even if a pop occurs
//   in the same cycle.
//  RX pop: rx_rd & ~rx_empty advances rd_ptr. rx_rd & rx_empty sets rx_udf; no pointer change.
//  Simultaneous push and pop on one FIFO: both occur, level unchanged.
//  FSM states and transitions:
//   IDLE -> LOAD when en & ~tx_empty & ~rx_full & ~busy
//   LOAD: datai <= TX head, pop TX, go <= 1 (registered) -> WAIT
//   WAIT: go <= 0; on done: push datao into RX -> IDLE
//  RX space is reserved at LOAD; the host cannot push RX, so the capture never overflows.
//  Timing: first go pulse is 2 cycles after the tx_wr cycle when idle and en=1.
//   Back-to-back bytes: next go is 2 cycles after done.
//  en deasserted during LOAD/WAIT: the current byte completes and is captured.
//   No further starts.
//  flush: clears both FIFOs in the next cycle.
//   In WAIT, the FSM still waits for done, then discards datao (no RX push).
//   A tx_wr or rx_rd in the same cycle as flush is ignored.
//  err_clr has priority below a same-cycle setting event; the flag stays 1.
//  done outside WAIT is ignored.
//  PRESETn asserted mid-transfer: immediate return to reset values.
//   spi_master is reset by the same PRESETn.
// TESTING
//  1. Reset, en=1, push 0xA5 -> go is a single pulse 2 cycles later with datai=0xA5.
//     Model returns 0x3C on done -> rx_level=1, rx_rdata=0x3C.
//  2. Push 4 bytes 11,22,33,44 with en=0, then en=1 -> exactly 4 go pulses in order.
//     Each go follows the previous done by 2 cycles. RX holds the 4 echoed bytes, rx_full=1.
//  3. RX full (4 entries) with TX holding 1 byte -> no go. Pop one RX entry -> go follows.
//  4. Push 5 bytes with en=0 -> 5th dropped, tx_ovf=1, tx_level=4.
//     rx_rd while RX empty -> rx_udf=1. err_clr clears both flags.
//  5. flush during WAIT -> both FIFOs empty next cycle. Done received, no RX push,
//     state returns to IDLE.
//  6. Push then pop across pointer wrap (6 transfers total) -> data order preserved.
//     PRESETn pulse in WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/spi_xfer_fifo_seq.sv
// Byte sequencer for spi_master: a TX FIFO feeds one go pulse per byte, and each received byte is pushed into an RX FIFO.
// go is registered and rises on the 2nd edge after a byte becomes sendable; only one transfer is in flight at a time.
module spi_xfer_fifo_seq #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          en,
  input  logic          flush,
  input  logic          err_clr,
  input  logic          tx_wr,
  input  logic [DW-1:0] tx_wdata,
  input  logic          rx_rd,
  output logic [DW-1:0] rx_rdata,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [AW:0]   tx_level,
  output logic          rx_full,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          tx_ovf,
  output logic          rx_udf,
  output logic          xfer_active,
  output logic          go,
  output logic [DW-1:0] datai,
  input  logic [DW-1:0] datao,
  input  logic          busy,
  input  logic          done
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} state_e;

  state_e        state_q;
  logic          go_q;
  logic          discard_q;
  logic [DW-1:0] datai_q;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic [DW-1:0] tx_head, rx_head;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_ovf_set, rx_udf_set, start;

  // A flush cycle swallows host accesses entirely, including their error flags.
  assign tx_push    = tx_wr & ~tx_full  & ~flush;
  assign tx_ovf_set = tx_wr &  tx_full  & ~flush;
  assign rx_pop     = rx_rd & ~rx_empty & ~flush;
  assign rx_udf_set = rx_rd &  rx_empty & ~flush;
  assign tx_pop     = (state_q == ST_LOAD) & ~tx_empty;
  assign rx_push    = (state_q == ST_WAIT) & done & ~discard_q & ~flush;
  assign start      = en & ~tx_empty & ~rx_full & ~busy & ~flush;

  spi_xfer_fifo_seq_fifo #(.DW(DW), .AW(AW)) u_tx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .flush (flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (tx_wdata),
    .head  (tx_head),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_xfer_fifo_seq_fifo #(.DW(DW), .AW(AW)) u_rx_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .flush (flush),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (datao),
    .head  (rx_head),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // A same-cycle setting event wins over err_clr.
  always_comb begin
    tx_ovf_d = tx_ovf_q & ~err_clr;
    rx_udf_d = rx_udf_q & ~err_clr;
    if (tx_ovf_set) tx_ovf_d = 1'b1;
    if (rx_udf_set) rx_udf_d = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  // discard_q marks a transfer whose received byte must be dropped because a flush hit it in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      go_q      <= 1'b0;
      datai_q   <= '0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          go_q      <= 1'b0;
          discard_q <= 1'b0;
          if (start) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          datai_q   <= tx_head;
          go_q      <= 1'b1;
          discard_q <= flush;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          go_q <= 1'b0;
          if (done) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          go_q      <= 1'b0;
          discard_q <= 1'b0;
        end
      endcase
    end
  end

  assign go          = go_q;
  assign datai       = datai_q;
  assign xfer_active = (state_q != ST_IDLE);
  assign tx_ovf      = tx_ovf_q;
  assign rx_udf      = rx_udf_q;
  assign rx_rdata    = rx_empty ? '0 : rx_head;

endmodule

// Circular FIFO with a show-ahead head. Push and pop arrive pre-qualified by the parent module.
// A flush resets the pointers and the level on the next edge and takes priority over push and pop.
module spi_xfer_fifo_seq_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);

endmodule
